// File: rtl/bcd_pkg.sv
// Shared BCD definitions: FSM state encoding, digit constants and a digit-validity helper.
package bcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SUB,
    NEGATE,
    DONE
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [4:0] BCD_BASE = 5'd10;

  function automatic logic is_bcd_digit(input logic [3:0] v);
    return (v <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of x - y - bin with decimal borrow correction.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic signed [4:0] t;

  // Range is -16..15, so the 5-bit signed intermediate never wraps.
  always_comb begin
    t    = signed'({1'b0, x} - {1'b0, y} - {4'b0000, bin});
    bout = (t < 0);
    d    = bout ? 4'(t + signed'(BCD_BASE)) : t[3:0];
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor returning sign-magnitude |A-B| with a start/done handshake.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] DIFF,
  output logic                NEG,
  output logic                INVALID
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    diff_q, diff_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            borrow_q, borrow_d;
  logic            neg_q, neg_d;
  logic            invalid_q, invalid_d;

  logic [3:0]      op_x, op_y, dig;
  logic            dig_bout;
  logic            any_bad;

  // SUB works on a_i - b_i; NEGATE reuses the same digit unit as 0 - d_i.
  always_comb begin
    op_x = (state_q == NEGATE) ? 4'd0 : a_q[idx_q*4 +: 4];
    op_y = (state_q == NEGATE) ? diff_q[idx_q*4 +: 4] : b_q[idx_q*4 +: 4];
  end

  bcd_digit_sub u_digit (
    .x    (op_x),
    .y    (op_y),
    .bin  (borrow_q),
    .d    (dig),
    .bout (dig_bout)
  );

  always_comb begin
    any_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!is_bcd_digit(a_q[k*4 +: 4]) || !is_bcd_digit(b_q[k*4 +: 4])) any_bad = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    idx_d     = idx_q;
    borrow_d  = borrow_q;
    neg_d     = neg_q;
    invalid_d = invalid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          state_d = CHECK;
        end
      end
      CHECK: begin
        diff_d    = '0;
        neg_d     = 1'b0;
        idx_d     = '0;
        borrow_d  = 1'b0;
        invalid_d = any_bad;
        state_d   = any_bad ? DONE : SUB;
      end
      SUB: begin
        diff_d[idx_q*4 +: 4] = dig;
        borrow_d             = dig_bout;
        idx_d                = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          if (dig_bout) begin
            // A < B: the partial result is the ten's complement of the magnitude.
            neg_d    = 1'b1;
            idx_d    = '0;
            borrow_d = 1'b0;
            state_d  = NEGATE;
          end else begin
            state_d = DONE;
          end
        end
      end
      NEGATE: begin
        diff_d[idx_q*4 +: 4] = dig;
        borrow_d             = dig_bout;
        idx_d                = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          borrow_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      idx_q     <= '0;
      borrow_q  <= 1'b0;
      neg_q     <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      diff_q    <= diff_d;
      idx_q     <= idx_d;
      borrow_q  <= borrow_d;
      neg_q     <= neg_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = (state_q == CHECK) || (state_q == SUB) || (state_q == NEGATE);
  assign done    = (state_q == DONE);
  assign DIFF    = diff_q;
  assign NEG     = neg_q;
  assign INVALID = invalid_q;

endmodule

// File: doc/bcd_serial_subtractor.md
Name: bcd_serial_subtractor

Overview:
- Digit-serial, multi-digit packed-BCD subtractor; it is the subtraction counterpart of the team's BCD adder.
- Computes A − B one BCD digit per clock, least significant digit first.
- Returns a sign-magnitude result: BCD magnitude plus a negative flag.
- Uses a start/done handshake, so a datapath controller can issue operations and collect results.

Parameters:
- DIGITS, 2, number of packed BCD digits per operand (≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  4*DIGITS  minuend, packed BCD, digit 0 in [3:0].
- B  input  4*DIGITS  subtrahend, packed BCD.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse; result valid from this cycle onward.
- DIFF  output  4*DIGITS  BCD magnitude |A − B|.
- NEG  output  1  1 when A < B.
- INVALID  output  1  1 when any digit of the latched A or B is greater than 9.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, DIFF=0, NEG=0, INVALID=0.
  - Internal digit index and borrow cleared.
  - Applies at any point, including mid-operation; the in-flight result is discarded and no done is produced.
- States: IDLE, CHECK, SUB, NEGATE, DONE.
- IDLE:
  - If start=1, latch A and B, go to CHECK, and set busy=1.
  - Outputs DIFF, NEG and INVALID hold the previous result until CHECK.
- CHECK (one cycle):
  - Clear DIFF, NEG, INVALID, index and borrow.
  - If any latched digit is greater than 9: set INVALID=1, go to DONE, DIFF stays 0.
  - Otherwise go to SUB.
- SUB (DIGITS cycles, index i = 0..DIGITS−1):
  - t = a_i − b_i − borrow.
  - If t < 0: digit = t + 10, borrow = 1. Else digit = t, borrow = 0.
  - Write digit i of DIFF and increment i.
  - After the last digit: if borrow = 0, go to DONE. If borrow = 1, set NEG=1, clear i and borrow, and go to NEGATE.
- NEGATE (DIGITS cycles):
  - Forms the ten's complement of DIFF in place, digit-serially.
  - t = 0 − d_i − borrow, with the same ±10 correction as SUB.
  - After the last digit go to DONE; the final borrow is ignored.
- DONE (one cycle): done=1 and busy=0 in this cycle, then go to IDLE.
- Latency from the accept edge to the done cycle:
  - Valid operands, A ≥ B: DIGITS+2 cycles.
  - Valid operands, A < B: 2*DIGITS+2 cycles.
  - Invalid operands: 2 cycles.
- Boundary conditions:
  - start is ignored while busy=1 or in DONE; there is no queueing.
  - A change on A or B after acceptance has no effect.
  - A = B gives DIFF=0, NEG=0. Negative zero is never produced.
  - The maximum magnitude (all 9s) is representable; there is no overflow output.
  - start held high continuously causes back-to-back operations, one every latency+1 cycles.
- Widths:
  - Per-digit arithmetic uses a 5-bit signed intermediate.
  - Each result digit is in 0..9, guaranteed for valid inputs.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum {IDLE, CHECK, SUB, NEGATE, DONE};
  - localparams BCD_MAX=9 and BCD_BASE=10;
  - the function is_bcd_digit(4-bit).
- Sub-module bcd_digit_sub is natural:
  - combinational; inputs x[3:0], y[3:0], bin; outputs d[3:0], bout;
  - one instance shared by SUB (x=a_i, y=b_i) and NEGATE (x=0, y=d_i) through an operand mux.
- The top level holds the FSM, the digit index counter, the borrow register, and the operand and result shift/index registers.

Test Plan:
- Positive result: DIGITS=2, A=0x83, B=0x27, start pulse → done at accept+4, DIFF=0x56, NEG=0, INVALID=0.
- Negative result: A=0x27, B=0x83 → done at accept+6, DIFF=0x56, NEG=1; also A=0x00, B=0x99 → DIFF=0x99, NEG=1.
- Equal and zero operands: A=0x50, B=0x50 → DIFF=0x00, NEG=0. A=0x00, B=0x00 → DIFF=0x00, NEG=0. A=0x10, B=0x01 → DIFF=0x09, NEG=0 (borrow chain).
- Invalid digit: A=0x3A, B=0x12 → done at accept+2, INVALID=1, DIFF=0x00, NEG=0. Then a valid op A=0x45, B=0x12 → DIFF=0x33, INVALID=0.
- Protocol:
  - Pulse start again during busy and change A/B mid-operation → no effect; a single done pulse with the original result.
  - start held high for 3 operations → done pulses spaced exactly latency+1 cycles apart.
- Reset mid-operation: assert rst_n=0 during NEGATE of 0x27−0x83 → immediately busy=0, done=0, DIFF=0, NEG=0; after release, A=0x91, B=0x19 → DIFF=0x72, NEG=0.
